score_renderer: RTL and testbench
=================================

SCORE_RENDERER -- requirements
Module: score_renderer

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of decimal digits displayed (1..6).
REQ-002 Parameter SCORE_W, default 14: binary score width (4..20).
REQ-003 Parameter X0, default 10'd560: left pixel column of the leftmost digit.
REQ-004 Parameter Y0, default 10'd16: top pixel row of the digit band.
REQ-005 Clk  input  1  system clock; all logic on rising edge.
REQ-006 Reset_n  input  1  reset, synchronous, active-low.
REQ-007 score  input  SCORE_W  binary score to display.
REQ-008 score_valid  input  1  score presented for capture.
REQ-009 score_ready  output  1  block can accept a score.
REQ-010 DrawX  input  10  current pixel column from the VGA controller.
REQ-011 DrawY  input  10  current pixel row from the VGA controller.
REQ-012 pixel_on  output  1  registered: current pixel is a lit glyph pixel.
REQ-013 busy  output  1  conversion in progress.

Function
REQ-014 FSM states IDLE, CONVERT, COMMIT; score_ready = (state == IDLE), busy = (state != IDLE).
REQ-015 IDLE: score_valid && score_ready captures score into a shift register, clears BCD accumulator, enters CONVERT.
REQ-016 CONVERT: one shift-add-3 (double-dabble) step per cycle, exactly SCORE_W cycles, then COMMIT.
REQ-017 COMMIT: one cycle; copies BCD result into display digit register; returns to IDLE.
REQ-018 Capture-to-display latency SCORE_W+1 cycles after the accepting edge; score_ready low for that whole window.
REQ-019 score_valid while not ready is ignored; no queueing; the source holds score_valid until accepted.
REQ-020 Score > 10^NUM_DIGITS-1 saturates: every displayed digit is 9.
REQ-021 Display digit register changes only in COMMIT; pixel path never sees a partial conversion.
REQ-022 Glyph cell 8 wide x 16 tall; digit k (k=0 leftmost, most significant) occupies columns X0+8k..X0+8k+7, rows Y0..Y0+15.
REQ-023 Glyph ROM: digit d, row r at address d*16+r; bit 7 = leftmost pixel; rows 0-3 and 14-15 blank.
REQ-024 pixel_on(t+1) = ROM bit for (DrawX,DrawY) at t if inside the band, else 0; exactly one cycle of latency.
REQ-025 Coordinates left of X0, above Y0, or beyond the band (including DrawX at 10-bit wrap) give pixel_on 0.
REQ-026 Accepting handshake and pixel lookup in the same cycle: lookup uses the old display value.

Reset
REQ-027 Reset_n low at a rising edge: state IDLE, display digits all 0, BCD/shift registers 0, pixel_on 0, busy 0; score_ready 1 from the first edge after release.
REQ-028 Reset mid-CONVERT aborts conversion; display shows 0 after reset, not the in-flight score.

Configuration
REQ-029 Macro SCORE_LEADING_ZERO_BLANK_EN defined: leading zero digits are blanked, pixel_on 0 across their cells; digit NUM_DIGITS-1 is always drawn, so score 0 shows a single "0".
REQ-030 Macro undefined: all NUM_DIGITS digits drawn, including leading zeros.

Structure
REQ-031 Shared package score_pkg holds GLYPH_W=8, GLYPH_H=16, the state enum type, and the BCD digit typedef (4-bit).
REQ-032 Sub-module digit_glyph_rom: 160x8 combinational glyph ROM for digits 0-9; 8-bit address in, 8-bit row out.

Verification
REQ-033 Reset, then DrawX=X0+8*3+1, DrawY=Y0+4 -> pixel_on matches ROM row 4 of "0", bit 6, one cycle later; score_ready=1.
REQ-034 score=1234 with valid for 1 cycle -> ready low 15 cycles, display digits 1,2,3,4; scanning the band reproduces the glyph bitmaps.
REQ-035 score=16383 -> display 9,9,9,9 (saturation).
REQ-036 Second valid during CONVERT with score=42 -> ignored; display shows the first score.
REQ-037 Reset_n low at the 5th CONVERT cycle of score=777 -> display 0000, state IDLE.
REQ-038 With SCORE_LEADING_ZERO_BLANK_EN defined, score=7 -> only cell k=3 lit; without it, "0007" drawn.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and constants for the score renderer: glyph geometry, FSM states, BCD digits.
package score_pkg;

   localparam int GLYPH_W = 8;
   localparam int GLYPH_H = 16;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_COMMIT  = 2'd2
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   function automatic int unsigned pow10(input int n);
      int unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

endpackage

// File: rtl/digit_glyph_rom.sv
// 160x8 combinational glyph ROM: address = digit*16 + row, bit 7 is the leftmost pixel.
module digit_glyph_rom
   import score_pkg::*;
(
   input  logic [7:0] i_addr,
   output logic [7:0] o_row
);

   // Each entry packs the ten drawn rows 4..13, row 4 in the top byte; rows 0-3 and 14-15 are blank.
   localparam logic [79:0] GLYPHS [10] = '{
      80'h3C66666E76666666663C,
      80'h1838781818181818187E,
      80'h3C6606060C183060667E,
      80'h3C6606061C060606663C,
      80'h0C1C3C6CCCFE0C0C0C1E,
      80'h7E6060607C060606663C,
      80'h1C3060607C666666663C,
      80'h7E6606060C1818181818,
      80'h3C6666663C666666663C,
      80'h3C6666663E0606060C38
   };

   logic [3:0] w_digit;
   logic [3:0] w_row;

   assign w_digit = i_addr[7:4];
   assign w_row   = i_addr[3:0];

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      o_row = '0;
      if (w_digit <= 4'd9 && w_row >= 4'd4 && w_row <= 4'd13)
         o_row = GLYPHS[w_digit][8*(13 - int'(w_row)) +: 8];
   end

endmodule

// File: rtl/score_renderer.sv
// Binary score -> BCD (double-dabble, one bit per cycle) -> glyph pixels for a VGA scan.
// Optional macro SCORE_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module score_renderer
   import score_pkg::*;
#(
   parameter int         NUM_DIGITS = 4,
   parameter int         SCORE_W    = 14,
   parameter logic [9:0] X0         = 10'd560,
   parameter logic [9:0] Y0         = 10'd16
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [SCORE_W-1:0] score,
   input  logic               score_valid,
   output logic               score_ready,
   input  logic [9:0]         DrawX,
   input  logic [9:0]         DrawY,
   output logic               pixel_on,
   output logic               busy
);

   localparam int          ACC_DIGITS = SCORE_W / 3 + 1;
   localparam int          ACC_W      = 4 * ACC_DIGITS;
   localparam int          WIDE       = (ACC_DIGITS > NUM_DIGITS) ? ACC_DIGITS : NUM_DIGITS;
   localparam int          CNT_W      = $clog2(SCORE_W + 1);
   localparam int unsigned MAX_SCORE  = pow10(NUM_DIGITS) - 1;
   localparam int          BAND_W     = GLYPH_W * NUM_DIGITS;

   state_t                        r_state, w_state_next;
   logic [SCORE_W-1:0]            r_shift;
   logic [ACC_W-1:0]              r_bcd, w_bcd_adj, w_bcd_step;
   logic [4*WIDE-1:0]             w_bcd_wide;
   logic [CNT_W-1:0]              r_cnt;
   logic                          r_sat;
   bcd_digit_t [NUM_DIGITS-1:0]   r_disp;
   logic                          r_pixel_on;

   assign score_ready = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign w_bcd_wide  = (4*WIDE)'(r_bcd);

   // Add-3 correction on every digit >= 5, then shift the next score bit in.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < ACC_DIGITS; i++)
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      w_bcd_step = {w_bcd_adj[ACC_W-2:0], r_shift[SCORE_W-1]};
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (score_valid) w_state_next = S_CONVERT;
         S_CONVERT: if (r_cnt == CNT_W'(SCORE_W - 1)) w_state_next = S_COMMIT;
         S_COMMIT:  w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         // NOTE: the display register is reset, so an aborted conversion always leaves a clean 0.
         r_state <= S_IDLE;
         r_shift <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
         r_sat   <= 1'b0;
         r_disp  <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_IDLE: if (score_valid) begin
               r_shift <= score;
               r_bcd   <= '0;
               r_cnt   <= '0;
               r_sat   <= 32'(score) > MAX_SCORE;
            end
            S_CONVERT: begin
               r_shift <= r_shift << 1;
               r_bcd   <= w_bcd_step;
               r_cnt   <= r_cnt + CNT_W'(1);
            end
            S_COMMIT:
               for (int k = 0; k < NUM_DIGITS; k++)
                  r_disp[k] <= r_sat ? 4'd9 : w_bcd_wide[4*(NUM_DIGITS-1-k) +: 4];
            default: ;
         endcase
      end
   end

   // Pixel path; 11-bit arithmetic keeps DrawX near 1023 from wrapping into the band.
   logic [10:0] w_x_rel, w_y_rel;
   logic        w_in_band;
   logic [2:0]  w_cell;
   bcd_digit_t  w_digit;
   logic        w_blank;
   logic [7:0]  w_rom_row;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
   logic        w_zero_run;
`endif

   assign w_x_rel   = {1'b0, DrawX} - {1'b0, X0};
   assign w_y_rel   = {1'b0, DrawY} - {1'b0, Y0};
   assign w_in_band = (DrawX >= X0) && (w_x_rel < 11'(BAND_W)) &&
                      (DrawY >= Y0) && (w_y_rel < 11'(GLYPH_H));
   assign w_cell    = w_x_rel[5:3];

   always_comb begin
      w_digit = '0;
      w_blank = 1'b0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      w_zero_run = 1'b1;
`endif
      for (int k = 0; k < NUM_DIGITS; k++) begin
`ifdef SCORE_LEADING_ZERO_BLANK_EN
         w_zero_run = w_zero_run && (r_disp[k] == 4'd0);
`endif
         if (w_cell == 3'(k)) begin
            w_digit = r_disp[k];
`ifdef SCORE_LEADING_ZERO_BLANK_EN
            w_blank = w_zero_run && (k != NUM_DIGITS - 1);
`endif
         end
      end
   end

   digit_glyph_rom u_rom (
      .i_addr ({w_digit, w_y_rel[3:0]}),
      .o_row  (w_rom_row)
   );

   always_ff @(posedge Clk) begin
      if (!Reset_n) r_pixel_on <= 1'b0;
      else          r_pixel_on <= w_in_band && !w_blank && w_rom_row[3'd7 - w_x_rel[2:0]];
   end

   assign pixel_on = r_pixel_on;

endmodule

// File: tb/tb_score_renderer.sv
// Self-checking bench for score_renderer: vector table, corner sequences, random scores vs model.
module tb_score_renderer;

   localparam int         ND = 4;
   localparam int         SW = 14;
   localparam logic [9:0] X0 = 10'd560;
   localparam logic [9:0] Y0 = 10'd16;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic [SW-1:0] score = '0;
   logic          score_valid = 1'b0;
   logic [9:0]    DrawX = '0;
   logic [9:0]    DrawY = '0;
   logic          score_ready, pixel_on, busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   score_renderer #(.NUM_DIGITS(ND), .SCORE_W(SW), .X0(X0), .Y0(Y0)) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .score       (score),
      .score_valid (score_valid),
      .score_ready (score_ready),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .pixel_on    (pixel_on),
      .busy        (busy)
   );

   function automatic logic [79:0] glyph(input int d);
      case (d)
         0: return 80'h3C66666E76666666663C;
         1: return 80'h1838781818181818187E;
         2: return 80'h3C6606060C183060667E;
         3: return 80'h3C6606061C060606663C;
         4: return 80'h0C1C3C6CCCFE0C0C0C1E;
         5: return 80'h7E6060607C060606663C;
         6: return 80'h1C3060607C666666663C;
         7: return 80'h7E6606060C1818181818;
         8: return 80'h3C6666663C666666663C;
         9: return 80'h3C6666663E0606060C38;
         default: return '0;
      endcase
   endfunction

   // Reference: decimal digits of the saturated value, looked up in the font by cell/row/column.
   function automatic logic exp_pixel(input int x, input int y, input int value);
      int v, k, row, col, p, d;
      logic [79:0] g;
      logic [7:0]  bits;
      if (x < int'(X0) || x >= int'(X0) + 8*ND || y < int'(Y0) || y >= int'(Y0) + 16) return 1'b0;
      v = (value > 9999) ? 9999 : value;
      k = (x - int'(X0)) / 8;
      col = (x - int'(X0)) % 8;
      row = y - int'(Y0);
      p = 1;
      for (int i = 0; i < ND - 1 - k; i++) p = p * 10;
      d = (v / p) % 10;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      if (k != ND - 1 && v < p) return 1'b0;
`endif
      if (row < 4 || row > 13) return 1'b0;
      g = glyph(d);
      bits = g[8*(13 - row) +: 8];
      return bits[7 - col];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic scan(input int value, input string tag);
      for (int y = int'(Y0) - 1; y <= int'(Y0) + 16; y++)
         for (int x = int'(X0) - 2; x <= int'(X0) + 8*ND + 1; x++) begin
            DrawX = 10'(x);
            DrawY = 10'(y);
            tick();
            check($sformatf("%s px(%0d,%0d)", tag, x, y), 32'(pixel_on), 32'(exp_pixel(x, y, value)));
         end
   endtask

   // Accept one score while watching a fixed pixel that must keep showing the old value.
   task automatic send(input int s, input int old_value);
      int n;
      DrawX = X0 + 10'd26;
      DrawY = Y0 + 10'd8;
      score = SW'(s);
      score_valid = 1'b1;
      tick();
      score_valid = 1'b0;
      n = 0;
      while (score_ready !== 1'b1 && n < 40) begin
         n++;
         check($sformatf("busy during conv %0d", s), 32'(busy), 32'd1);
         check($sformatf("old px during conv %0d", s), 32'(pixel_on),
               32'(exp_pixel(int'(X0) + 26, int'(Y0) + 8, old_value)));
         tick();
      end
      check($sformatf("ready-low cycles %0d", s), 32'(n), 32'(SW + 1));
      check($sformatf("busy after conv %0d", s), 32'(busy), 32'd0);
   endtask

   typedef struct {
      int sc;
      int disp;
   } vec_t;

   typedef struct {
      int   x;
      int   y;
      logic px;
   } pvec_t;

   initial begin
      vec_t  vecs [7];
      pvec_t pvecs [5];
      int    cur, n;

      vecs = '{'{1234, 1234}, '{16383, 9999}, '{0, 0}, '{9999, 9999},
               '{10000, 9999}, '{7, 7}, '{42, 42}};
      // Taken with "0042" on display.
      pvecs = '{'{1023, 24, 1'b0}, '{559, 24, 1'b0}, '{592, 24, 1'b0},
                '{586, 1023, 1'b0}, '{586, 20, 1'b1}};

      tick();
      tick();
      check("reset ready", 32'(score_ready), 32'd1);
      check("reset busy", 32'(busy), 32'd0);
      check("reset pixel_on", 32'(pixel_on), 32'd0);
      Reset_n = 1'b1;

      DrawX = X0 + 10'd25;
      DrawY = Y0 + 10'd4;
      tick();
      check("post-reset px row4 bit6", 32'(pixel_on), 32'(exp_pixel(int'(X0) + 25, int'(Y0) + 4, 0)));
      check("post-reset ready", 32'(score_ready), 32'd1);
      scan(0, "reset");
      cur = 0;

      for (int i = 0; i < 7; i++) begin
         send(vecs[i].sc, cur);
         scan(vecs[i].disp, $sformatf("vec%0d", vecs[i].sc));
         cur = vecs[i].disp;
      end

      for (int i = 0; i < 5; i++) begin
         DrawX = 10'(pvecs[i].x);
         DrawY = 10'(pvecs[i].y);
         tick();
         check($sformatf("edge px(%0d,%0d)", pvecs[i].x, pvecs[i].y), 32'(pixel_on), 32'(pvecs[i].px));
      end

      // A valid pulse during CONVERT must be dropped.
      score = SW'(555);
      score_valid = 1'b1;
      tick();
      score_valid = 1'b0;
      tick();
      tick();
      score = SW'(42);
      score_valid = 1'b1;
      tick();
      check("ready low on ignored valid", 32'(score_ready), 32'd0);
      tick();
      tick();
      score_valid = 1'b0;
      n = 0;
      while (score_ready !== 1'b1 && n < 40) begin
         n++;
         tick();
      end
      check("ignored valid: done in time", 32'(n < 40), 32'd1);
      tick();
      check("ignored valid: stays idle", 32'(busy), 32'd0);
      scan(555, "ignore42");
      cur = 555;

      // Reset at the fifth CONVERT edge aborts 777.
      score = SW'(777);
      score_valid = 1'b1;
      tick();
      score_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("busy before abort", 32'(busy), 32'd1);
      Reset_n = 1'b0;
      tick();
      Reset_n = 1'b1;
      check("abort ready", 32'(score_ready), 32'd1);
      check("abort busy", 32'(busy), 32'd0);
      for (int i = 0; i < 20; i++) tick();
      check("abort stays idle", 32'(busy), 32'd0);
      scan(0, "abort777");
      cur = 0;

      for (int i = 0; i < 8; i++) begin
         int s;
         s = int'($urandom_range(0, 16383));
         send(s, cur);
         scan(s, $sformatf("rnd%0d", s));
         cur = s;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
